// File: rtl/udt_rx_parser.sv
// udt_rx_parser: splits the UDP receive stream into UDT data payload and control descriptors.
// Statistics counters are built only when the UDT_RX_STATS_EN macro is defined.
module udt_rx_parser #(
    parameter logic [15:0] PORT   = 16'd10086,
    parameter int          STAT_W = 16
) (
    input  logic              udp_clk,
    input  logic              udp_aresetn,
    input  logic              udp_rx_tvalid,
    output logic              udp_rx_tready,
    input  logic [63:0]       udp_rx_tdata,
    input  logic [7:0]        udp_rx_tkeep,
    input  logic              udp_rx_tlast,
    input  logic [31:0]       udp_rx_ip_src,
    input  logic [15:0]       udp_rx_port_src,
    input  logic [15:0]       udp_rx_port_dest,
    output logic              udt_rx_data_tvalid,
    input  logic              udt_rx_data_tready,
    output logic [63:0]       udt_rx_data_tdata,
    output logic [7:0]        udt_rx_data_tkeep,
    output logic              udt_rx_data_tlast,
    output logic [30:0]       udt_rx_data_seq,
    output logic              udt_rx_ctrl_valid,
    input  logic              udt_rx_ctrl_ready,
    output logic [14:0]       udt_rx_ctrl_type,
    output logic [15:0]       udt_rx_ctrl_ext,
    output logic [63:0]       udt_rx_ctrl_body,
    output logic [31:0]       udt_rx_hdr_w1,
    output logic [31:0]       udt_rx_hdr_ts,
    output logic [31:0]       udt_rx_hdr_sock,
    output logic [31:0]       udt_rx_peer_ip,
    output logic [15:0]       udt_rx_peer_port,
    output logic [STAT_W-1:0] stat_data_pkts,
    output logic [STAT_W-1:0] stat_ctrl_pkts,
    output logic [STAT_W-1:0] stat_drop_port,
    output logic [STAT_W-1:0] stat_drop_runt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR1,
        S_DATA,
        S_CBODY,
        S_COUT,
        S_DROP
    } state_t;

    state_t      state_q;
    logic        run_q;
    logic        ctrlPend_q;
    logic [31:0] word0_q;
    logic [31:0] word1_q;
    logic [31:0] ts_q;
    logic [31:0] sock_q;
    logic [31:0] peerIp_q;
    logic [15:0] peerPort_q;
    logic [63:0] body_q;
    logic        ctrlValid_q;
    logic        dataValid_q;
    logic [63:0] dataData_q;
    logic [7:0]  dataKeep_q;
    logic        dataLast_q;

    logic        inReady;
    logic        inAcc;
    logic        portMatch;
    logic [31:0] beatWordA;
    logic [31:0] beatWordB;
    logic [63:0] bodyMasked;

    always_comb begin
        beatWordA  = {udp_rx_tdata[7:0],   udp_rx_tdata[15:8],
                      udp_rx_tdata[23:16], udp_rx_tdata[31:24]};
        beatWordB  = {udp_rx_tdata[39:32], udp_rx_tdata[47:40],
                      udp_rx_tdata[55:48], udp_rx_tdata[63:56]};
        bodyMasked = '0;
        for (int i = 0; i < 8; i++) begin
            bodyMasked[8*i +: 8] = udp_rx_tkeep[i] ? udp_rx_tdata[8*i +: 8] : 8'h00;
        end
    end

    // In DATA, stop accepting once the packet's last beat sits in the output register,
    // so the next packet's beat 0 is only taken after the tlast handshake.
    always_comb begin
        inReady = 1'b0;
        case (state_q)
            S_IDLE, S_HDR1, S_CBODY, S_DROP: inReady = 1'b1;
            S_DATA:  inReady = (!dataValid_q || udt_rx_data_tready) && !(dataValid_q && dataLast_q);
            default: inReady = 1'b0;
        endcase
        inReady = inReady && run_q;
    end

    assign portMatch     = (udp_rx_port_dest == PORT);
    assign inAcc         = udp_rx_tvalid && inReady;
    assign udp_rx_tready = inReady;

    always_ff @(posedge udp_clk or negedge udp_aresetn) begin
        if (!udp_aresetn) begin
            state_q     <= S_IDLE;
            run_q       <= 1'b0;
            ctrlPend_q  <= 1'b0;
            word0_q     <= '0;
            word1_q     <= '0;
            ts_q        <= '0;
            sock_q      <= '0;
            peerIp_q    <= '0;
            peerPort_q  <= '0;
            body_q      <= '0;
            ctrlValid_q <= 1'b0;
            dataValid_q <= 1'b0;
            dataData_q  <= '0;
            dataKeep_q  <= '0;
            dataLast_q  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (inAcc) begin
                        word0_q    <= beatWordA;
                        word1_q    <= beatWordB;
                        peerIp_q   <= udp_rx_ip_src;
                        peerPort_q <= udp_rx_port_src;
                        ctrlPend_q <= 1'b0;
                        if (!portMatch) begin
                            state_q <= udp_rx_tlast ? S_IDLE : S_DROP;
                        end else if (!udp_rx_tlast) begin
                            state_q <= S_HDR1;
                        end
                    end
                end
                S_HDR1: begin
                    if (inAcc) begin
                        ts_q   <= beatWordA;
                        sock_q <= beatWordB;
                        if (udp_rx_tlast) begin
                            if (udp_rx_tkeep == 8'hFF && word0_q[31]) begin
                                body_q      <= '0;
                                ctrlValid_q <= 1'b1;
                                state_q     <= S_COUT;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end else begin
                            state_q <= word0_q[31] ? S_CBODY : S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (inAcc) begin
                        dataData_q  <= udp_rx_tdata;
                        dataKeep_q  <= udp_rx_tkeep;
                        dataLast_q  <= udp_rx_tlast;
                        dataValid_q <= 1'b1;
                    end else if (udt_rx_data_tready) begin
                        dataValid_q <= 1'b0;
                    end
                    if (dataValid_q && dataLast_q && udt_rx_data_tready) begin
                        state_q <= S_IDLE;
                    end
                end
                S_CBODY: begin
                    if (inAcc) begin
                        body_q <= bodyMasked;
                        if (udp_rx_tlast) begin
                            ctrlValid_q <= 1'b1;
                            state_q     <= S_COUT;
                        end else begin
                            ctrlPend_q <= 1'b1;
                            state_q    <= S_DROP;
                        end
                    end
                end
                S_COUT: begin
                    if (udt_rx_ctrl_ready) begin
                        ctrlValid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                S_DROP: begin
                    // A long control packet parks here until its tail is gone, then emits.
                    if (inAcc && udp_rx_tlast) begin
                        if (ctrlPend_q) begin
                            ctrlPend_q  <= 1'b0;
                            ctrlValid_q <= 1'b1;
                            state_q     <= S_COUT;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign udt_rx_data_tvalid = dataValid_q;
    assign udt_rx_data_tdata  = dataData_q;
    assign udt_rx_data_tkeep  = dataKeep_q;
    assign udt_rx_data_tlast  = dataLast_q;
    assign udt_rx_data_seq    = word0_q[30:0];
    assign udt_rx_ctrl_valid  = ctrlValid_q;
    assign udt_rx_ctrl_type   = word0_q[30:16];
    assign udt_rx_ctrl_ext    = word0_q[15:0];
    assign udt_rx_ctrl_body   = body_q;
    assign udt_rx_hdr_w1      = word1_q;
    assign udt_rx_hdr_ts      = ts_q;
    assign udt_rx_hdr_sock    = sock_q;
    assign udt_rx_peer_ip     = peerIp_q;
    assign udt_rx_peer_port   = peerPort_q;

`ifdef UDT_RX_STATS_EN
    logic [STAT_W-1:0] statData_q;
    logic [STAT_W-1:0] statCtrl_q;
    logic [STAT_W-1:0] statPort_q;
    logic [STAT_W-1:0] statRunt_q;
    logic              incData;
    logic              incCtrl;
    logic              incPort;
    logic              incRunt;

    function automatic logic [STAT_W-1:0] satInc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        incPort = (state_q == S_IDLE) && inAcc && !portMatch;
        incRunt = inAcc && udp_rx_tlast &&
                  (((state_q == S_IDLE) && portMatch) ||
                   ((state_q == S_HDR1) && (udp_rx_tkeep != 8'hFF || !word0_q[31])));
        incData = (state_q == S_DATA) && dataValid_q && dataLast_q && udt_rx_data_tready;
        incCtrl = (state_q == S_COUT) && udt_rx_ctrl_ready;
    end

    always_ff @(posedge udp_clk or negedge udp_aresetn) begin
        if (!udp_aresetn) begin
            statData_q <= '0;
            statCtrl_q <= '0;
            statPort_q <= '0;
            statRunt_q <= '0;
        end else begin
            if (incData) statData_q <= satInc(statData_q);
            if (incCtrl) statCtrl_q <= satInc(statCtrl_q);
            if (incPort) statPort_q <= satInc(statPort_q);
            if (incRunt) statRunt_q <= satInc(statRunt_q);
        end
    end

    assign stat_data_pkts = statData_q;
    assign stat_ctrl_pkts = statCtrl_q;
    assign stat_drop_port = statPort_q;
    assign stat_drop_runt = statRunt_q;
`else
    assign stat_data_pkts = '0;
    assign stat_ctrl_pkts = '0;
    assign stat_drop_port = '0;
    assign stat_drop_runt = '0;
`endif

endmodule

// File: tb/tb_udt_rx_parser.sv
// tb_udt_rx_parser: directed checks of udt_rx_parser data, control, drop, runt and reset handling.
// Counter expectations follow whether UDT_RX_STATS_EN is defined for the build.
module tb_udt_rx_parser;

    localparam logic [15:0] PORT = 16'd10086;
`ifdef UDT_RX_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic        udp_clk = 1'b0;
    logic        udp_aresetn;
    logic        udp_rx_tvalid;
    logic        udp_rx_tready;
    logic [63:0] udp_rx_tdata;
    logic [7:0]  udp_rx_tkeep;
    logic        udp_rx_tlast;
    logic [31:0] udp_rx_ip_src;
    logic [15:0] udp_rx_port_src;
    logic [15:0] udp_rx_port_dest;
    logic        udt_rx_data_tvalid;
    logic        udt_rx_data_tready;
    logic [63:0] udt_rx_data_tdata;
    logic [7:0]  udt_rx_data_tkeep;
    logic        udt_rx_data_tlast;
    logic [30:0] udt_rx_data_seq;
    logic        udt_rx_ctrl_valid;
    logic        udt_rx_ctrl_ready;
    logic [14:0] udt_rx_ctrl_type;
    logic [15:0] udt_rx_ctrl_ext;
    logic [63:0] udt_rx_ctrl_body;
    logic [31:0] udt_rx_hdr_w1;
    logic [31:0] udt_rx_hdr_ts;
    logic [31:0] udt_rx_hdr_sock;
    logic [31:0] udt_rx_peer_ip;
    logic [15:0] udt_rx_peer_port;
    logic [15:0] stat_data_pkts;
    logic [15:0] stat_ctrl_pkts;
    logic [15:0] stat_drop_port;
    logic [15:0] stat_drop_runt;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic [30:0] seq;
    } beat_t;

    typedef struct {
        logic [14:0] typ;
        logic [15:0] ext;
        logic [63:0] body;
        logic [31:0] w1;
        logic [31:0] ts;
        logic [31:0] sock;
        logic [31:0] ip;
        logic [15:0] port;
    } ctrl_t;

    beat_t outQ[$];
    ctrl_t ctrlQ[$];
    int    total = 0;
    int    bad = 0;
    bit    randReady = 1'b0;

    udt_rx_parser #(.PORT(PORT), .STAT_W(16)) dut (
        .udp_clk            (udp_clk),
        .udp_aresetn        (udp_aresetn),
        .udp_rx_tvalid      (udp_rx_tvalid),
        .udp_rx_tready      (udp_rx_tready),
        .udp_rx_tdata       (udp_rx_tdata),
        .udp_rx_tkeep       (udp_rx_tkeep),
        .udp_rx_tlast       (udp_rx_tlast),
        .udp_rx_ip_src      (udp_rx_ip_src),
        .udp_rx_port_src    (udp_rx_port_src),
        .udp_rx_port_dest   (udp_rx_port_dest),
        .udt_rx_data_tvalid (udt_rx_data_tvalid),
        .udt_rx_data_tready (udt_rx_data_tready),
        .udt_rx_data_tdata  (udt_rx_data_tdata),
        .udt_rx_data_tkeep  (udt_rx_data_tkeep),
        .udt_rx_data_tlast  (udt_rx_data_tlast),
        .udt_rx_data_seq    (udt_rx_data_seq),
        .udt_rx_ctrl_valid  (udt_rx_ctrl_valid),
        .udt_rx_ctrl_ready  (udt_rx_ctrl_ready),
        .udt_rx_ctrl_type   (udt_rx_ctrl_type),
        .udt_rx_ctrl_ext    (udt_rx_ctrl_ext),
        .udt_rx_ctrl_body   (udt_rx_ctrl_body),
        .udt_rx_hdr_w1      (udt_rx_hdr_w1),
        .udt_rx_hdr_ts      (udt_rx_hdr_ts),
        .udt_rx_hdr_sock    (udt_rx_hdr_sock),
        .udt_rx_peer_ip     (udt_rx_peer_ip),
        .udt_rx_peer_port   (udt_rx_peer_port),
        .stat_data_pkts     (stat_data_pkts),
        .stat_ctrl_pkts     (stat_ctrl_pkts),
        .stat_drop_port     (stat_drop_port),
        .stat_drop_runt     (stat_drop_runt)
    );

    always #5 udp_clk = ~udp_clk;

    // Downstream data ready: always 1, or a coin flip per cycle while randReady is set.
    initial begin
        forever begin
            @(posedge udp_clk);
            #1;
            udt_rx_data_tready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Handshakes are recorded on the falling edge; inputs only change just after rising edges.
    initial begin
        forever begin
            @(negedge udp_clk);
            if (udp_aresetn && udt_rx_data_tvalid && udt_rx_data_tready)
                outQ.push_back('{udt_rx_data_tdata, udt_rx_data_tkeep,
                                 udt_rx_data_tlast, udt_rx_data_seq});
            if (udp_aresetn && udt_rx_ctrl_valid && udt_rx_ctrl_ready)
                ctrlQ.push_back('{udt_rx_ctrl_type, udt_rx_ctrl_ext, udt_rx_ctrl_body,
                                  udt_rx_hdr_w1, udt_rx_hdr_ts, udt_rx_hdr_sock,
                                  udt_rx_peer_ip, udt_rx_peer_port});
        end
    end

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [63:0] hdrBeat(input logic [31:0] wa, input logic [31:0] wb);
        return {bswap(wb), bswap(wa)};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] d, input logic [7:0] k,
                                 input logic l, input logic [15:0] port);
        bit ok;
        ok               = 1'b0;
        udp_rx_tvalid    = 1'b1;
        udp_rx_tdata     = d;
        udp_rx_tkeep     = k;
        udp_rx_tlast     = l;
        udp_rx_port_dest = port;
        for (int c = 0; c < 200; c++) begin
            @(negedge udp_clk);
            if (udp_rx_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("input_accept_timeout", 64'(ok), 64'd1);
        @(posedge udp_clk);
        #1;
        udp_rx_tvalid = 1'b0;
    endtask

    task automatic waitOutBeats(input int n);
        for (int c = 0; c < 500 && outQ.size() < n; c++) @(negedge udp_clk);
        checkOutput("data_beat_count", 64'(outQ.size()), 64'(n));
    endtask

    task automatic waitCtrl(input int n);
        for (int c = 0; c < 500 && ctrlQ.size() < n; c++) @(negedge udp_clk);
        checkOutput("ctrl_desc_count", 64'(ctrlQ.size()), 64'(n));
    endtask

    task automatic checkBeat(input int idx, input logic [63:0] d, input logic [7:0] k,
                             input logic l, input logic [30:0] seq);
        if (idx >= outQ.size()) begin
            checkOutput($sformatf("beat%0d_missing", idx), 64'(outQ.size()), 64'(idx + 1));
        end else begin
            checkOutput($sformatf("beat%0d_tdata", idx), outQ[idx].d, d);
            checkOutput($sformatf("beat%0d_tkeep", idx), 64'(outQ[idx].k), 64'(k));
            checkOutput($sformatf("beat%0d_tlast", idx), 64'(outQ[idx].l), 64'(l));
            checkOutput($sformatf("beat%0d_seq", idx), 64'(outQ[idx].seq), 64'(seq));
        end
    endtask

    task automatic checkCtrl(input logic [14:0] typ, input logic [15:0] ext, input logic [63:0] body,
                             input logic [31:0] w1, input logic [31:0] ts, input logic [31:0] sock);
        if (ctrlQ.size() == 0) begin
            checkOutput("ctrl_missing", 64'd0, 64'd1);
        end else begin
            checkOutput("ctrl_type", 64'(ctrlQ[0].typ), 64'(typ));
            checkOutput("ctrl_ext", 64'(ctrlQ[0].ext), 64'(ext));
            checkOutput("ctrl_body", ctrlQ[0].body, body);
            checkOutput("ctrl_w1", 64'(ctrlQ[0].w1), 64'(w1));
            checkOutput("ctrl_ts", 64'(ctrlQ[0].ts), 64'(ts));
            checkOutput("ctrl_sock", 64'(ctrlQ[0].sock), 64'(sock));
            checkOutput("ctrl_peer_ip", 64'(ctrlQ[0].ip), 64'h0000_0000_C0A8_0105);
            checkOutput("ctrl_peer_port", 64'(ctrlQ[0].port), 64'd5000);
        end
    endtask

    initial begin
        udp_aresetn        = 1'b0;
        udp_rx_tvalid      = 1'b0;
        udp_rx_tdata       = '0;
        udp_rx_tkeep       = '0;
        udp_rx_tlast       = 1'b0;
        udp_rx_ip_src      = 32'hC0A80105;
        udp_rx_port_src    = 16'd5000;
        udp_rx_port_dest   = '0;
        udt_rx_data_tready = 1'b1;
        udt_rx_ctrl_ready  = 1'b1;

        // Reset state
        repeat (3) @(posedge udp_clk);
        #1;
        checkOutput("rst_tready", 64'(udp_rx_tready), 64'd0);
        checkOutput("rst_data_tvalid", 64'(udt_rx_data_tvalid), 64'd0);
        checkOutput("rst_ctrl_valid", 64'(udt_rx_ctrl_valid), 64'd0);
        checkOutput("rst_data_tdata", udt_rx_data_tdata, 64'd0);
        checkOutput("rst_hdr_ts", 64'(udt_rx_hdr_ts), 64'd0);
        checkOutput("rst_stat_data", 64'(stat_data_pkts), 64'd0);
        udp_aresetn = 1'b1;
        @(posedge udp_clk);
        #1;

        // Data packet, 40 bytes; source IP/port are changed after beat 0 and must not be re-sampled
        applyStimulus(hdrBeat(32'h00000005, 32'h11223344), 8'hFF, 1'b0, PORT);
        udp_rx_ip_src   = 32'hFFFFFFFF;
        udp_rx_port_src = 16'hFFFF;
        applyStimulus(hdrBeat(32'hAABBCCDD, 32'h01020304), 8'hFF, 1'b0, 16'd0);
        applyStimulus(64'h0123456789ABCDEF, 8'hFF, 1'b0, 16'd0);
        applyStimulus(64'hFEDCBA9876543210, 8'hFF, 1'b0, 16'd0);
        applyStimulus(64'h5A5A5A5AC3C3C3C3, 8'hFF, 1'b1, 16'd0);
        waitOutBeats(3);
        checkBeat(0, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 31'd5);
        checkBeat(1, 64'hFEDCBA9876543210, 8'hFF, 1'b0, 31'd5);
        checkBeat(2, 64'h5A5A5A5AC3C3C3C3, 8'hFF, 1'b1, 31'd5);
        checkOutput("t1_hdr_w1", 64'(udt_rx_hdr_w1), 64'h11223344);
        checkOutput("t1_hdr_ts", 64'(udt_rx_hdr_ts), 64'hAABBCCDD);
        checkOutput("t1_hdr_sock", 64'(udt_rx_hdr_sock), 64'h01020304);
        checkOutput("t1_peer_ip", 64'(udt_rx_peer_ip), 64'hC0A80105);
        checkOutput("t1_peer_port", 64'(udt_rx_peer_port), 64'd5000);
        repeat (2) @(posedge udp_clk);
        #1;
        checkOutput("t1_stat_data", 64'(stat_data_pkts), STATS_ON ? 64'd1 : 64'd0);
        udp_rx_ip_src   = 32'hC0A80105;
        udp_rx_port_src = 16'd5000;

        // Control packet, 24 bytes
        outQ.delete();
        applyStimulus(hdrBeat(32'h80020000, 32'h00000007), 8'hFF, 1'b0, PORT);
        applyStimulus(hdrBeat(32'h12345678, 32'h9ABCDEF0), 8'hFF, 1'b0, PORT);
        applyStimulus(64'h8877665544332211, 8'hFF, 1'b1, PORT);
        waitCtrl(1);
        checkCtrl(15'd2, 16'h0000, 64'h8877665544332211, 32'h7, 32'h12345678, 32'h9ABCDEF0);
        repeat (2) @(posedge udp_clk);
        #1;
        checkOutput("t2_stat_ctrl", 64'(stat_ctrl_pkts), STATS_ON ? 64'd1 : 64'd0);

        // Control packet with partial body keep and a trailing beat to discard
        ctrlQ.delete();
        applyStimulus(hdrBeat(32'h8003ABCD, 32'h00000009), 8'hFF, 1'b0, PORT);
        applyStimulus(hdrBeat(32'h00000001, 32'h00000002), 8'hFF, 1'b0, PORT);
        applyStimulus(64'h1122334455667788, 8'h3F, 1'b0, PORT);
        checkOutput("t2b_ctrl_before_tlast", 64'(udt_rx_ctrl_valid), 64'd0);
        applyStimulus(64'hDEADDEADDEADDEAD, 8'hFF, 1'b1, PORT);
        waitCtrl(1);
        checkCtrl(15'd3, 16'hABCD, 64'h0000334455667788, 32'h9, 32'h1, 32'h2);

        // Header-only control packet carries a zero body
        ctrlQ.delete();
        applyStimulus(hdrBeat(32'h80050001, 32'h00000000), 8'hFF, 1'b0, PORT);
        applyStimulus(hdrBeat(32'h00000003, 32'h00000004), 8'hFF, 1'b1, PORT);
        waitCtrl(1);
        checkCtrl(15'd5, 16'h0001, 64'd0, 32'h0, 32'h3, 32'h4);
        repeat (2) @(posedge udp_clk);
        #1;
        checkOutput("t2_no_data_out", 64'(outQ.size()), 64'd0);
        checkOutput("t2c_stat_ctrl", 64'(stat_ctrl_pkts), STATS_ON ? 64'd3 : 64'd0);

        // Foreign destination port
        ctrlQ.delete();
        applyStimulus(hdrBeat(32'h00000001, 32'h0), 8'hFF, 1'b0, 16'd9999);
        applyStimulus(hdrBeat(32'h0, 32'h0), 8'hFF, 1'b0, 16'd9999);
        applyStimulus(64'h1111111111111111, 8'hFF, 1'b1, 16'd9999);
        repeat (4) @(posedge udp_clk);
        #1;
        checkOutput("t3_no_data_out", 64'(outQ.size()), 64'd0);
        checkOutput("t3_no_ctrl_out", 64'(ctrlQ.size()), 64'd0);
        checkOutput("t3_stat_port", 64'(stat_drop_port), STATS_ON ? 64'd1 : 64'd0);

        // Runts: 12-byte packet, then 8-byte packet
        applyStimulus(hdrBeat(32'h00000002, 32'h0), 8'hFF, 1'b0, PORT);
        applyStimulus(hdrBeat(32'h0, 32'h0), 8'h0F, 1'b1, PORT);
        applyStimulus(hdrBeat(32'h80000000, 32'h0), 8'hFF, 1'b1, PORT);
        repeat (4) @(posedge udp_clk);
        #1;
        checkOutput("t4_no_data_out", 64'(outQ.size()), 64'd0);
        checkOutput("t4_no_ctrl_out", 64'(ctrlQ.size()), 64'd0);
        checkOutput("t4_stat_runt", 64'(stat_drop_runt), STATS_ON ? 64'd2 : 64'd0);
        checkOutput("t4_stat_port", 64'(stat_drop_port), STATS_ON ? 64'd1 : 64'd0);

        // Random downstream ready with reset pulsed after the third payload beat is taken
        randReady = 1'b1;
        applyStimulus(hdrBeat(32'h0000002A, 32'h0), 8'hFF, 1'b0, PORT);
        applyStimulus(hdrBeat(32'h0, 32'h0), 8'hFF, 1'b0, PORT);
        applyStimulus(64'h1000000000000001, 8'hFF, 1'b0, PORT);
        applyStimulus(64'h2000000000000002, 8'hFF, 1'b0, PORT);
        applyStimulus(64'h3000000000000003, 8'hFF, 1'b0, PORT);
        udp_aresetn = 1'b0;
        checkOutput("t5_pre_rst_count", 64'(outQ.size()), 64'd2);
        checkBeat(0, 64'h1000000000000001, 8'hFF, 1'b0, 31'h2A);
        checkBeat(1, 64'h2000000000000002, 8'hFF, 1'b0, 31'h2A);
        #1;
        checkOutput("t5_rst_tvalid", 64'(udt_rx_data_tvalid), 64'd0);
        checkOutput("t5_rst_tdata", udt_rx_data_tdata, 64'd0);
        checkOutput("t5_rst_seq", 64'(udt_rx_data_seq), 64'd0);
        checkOutput("t5_rst_peer_port", 64'(udt_rx_peer_port), 64'd0);
        checkOutput("t5_rst_stat_runt", 64'(stat_drop_runt), 64'd0);
        repeat (2) @(posedge udp_clk);
        #1;
        udp_aresetn = 1'b1;
        repeat (2) @(posedge udp_clk);
        #1;
        outQ.delete();
        applyStimulus(hdrBeat(32'h00000077, 32'hDEADBEEF), 8'hFF, 1'b0, PORT);
        applyStimulus(hdrBeat(32'h00000055, 32'h00000066), 8'hFF, 1'b0, PORT);
        applyStimulus(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0, PORT);
        applyStimulus(64'hAAAA151413121110, 8'h3F, 1'b1, PORT);
        waitOutBeats(2);
        checkBeat(0, 64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0, 31'h77);
        checkBeat(1, 64'hAAAA151413121110, 8'h3F, 1'b1, 31'h77);
        checkOutput("t5_hdr_w1", 64'(udt_rx_hdr_w1), 64'hDEADBEEF);
        randReady = 1'b0;
        repeat (3) @(posedge udp_clk);
        #1;
        checkOutput("t5_stat_data", 64'(stat_data_pkts), STATS_ON ? 64'd1 : 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udt_rx_parser.md
# udt_rx_parser

- Receive-side packet classifier between the UDP stack's receive AXI-Stream (`udp_rx_*`) and the UDT core inside `udt_interface`.
- Accepts 64-bit UDP payload beats and filters on the destination port.
- Strips the 16-byte UDT header and routes each packet to one of two outputs:
  - data packets: header fields as sideband, payload as an aligned 64-bit stream;
  - control packets: decoded header plus the first 8 body bytes as a single descriptor.
- Malformed and foreign packets are discarded and counted.

## Interface
Parameters:
- `PORT`, 16'd10086, UDT listen port; packets with any other `udp_rx_port_dest` are dropped.
- `STAT_W`, 16, width of statistics counters.

Ports:
- `udp_clk`  in  1  the single clock, 156 MHz UDP domain.
- `udp_aresetn`  in  1  reset, asynchronous assert, active low.
- `udp_rx_tvalid` / `udp_rx_tready`  in / out  1  input handshake.
- `udp_rx_tdata`  in  64  payload; `[7:0]` is the first wire byte of the beat.
- `udp_rx_tkeep`  in  8  byte enables.
- `udp_rx_tlast`  in  1  last beat of the datagram.
- `udp_rx_ip_src`  in  32  peer IP; sampled on beat 0 only.
- `udp_rx_port_src`  in  16  peer port; sampled on beat 0 only.
- `udp_rx_port_dest`  in  16  destination port; sampled on beat 0 only.
- `udt_rx_data_tvalid` / `udt_rx_data_tready`  out / in  1  payload handshake.
- `udt_rx_data_tdata`  out  64  payload beat.
- `udt_rx_data_tkeep`  out  8  payload byte enables.
- `udt_rx_data_tlast`  out  1  last payload beat.
- `udt_rx_data_seq`  out  31  sequence number, header word0[30:0].
- `udt_rx_ctrl_valid` / `udt_rx_ctrl_ready`  out / in  1  control descriptor handshake.
- `udt_rx_ctrl_type`  out  15  header word0[30:16].
- `udt_rx_ctrl_ext`  out  16  header word0[15:0].
- `udt_rx_ctrl_body`  out  64  first body beat, raw byte order; disabled bytes zeroed.
- `udt_rx_hdr_w1`  out  32  header word1 (message number / additional info).
- `udt_rx_hdr_ts`  out  32  header word2, timestamp.
- `udt_rx_hdr_sock`  out  32  header word3, destination socket ID.
- `udt_rx_peer_ip`  out  32  latched `udp_rx_ip_src`.
- `udt_rx_peer_port`  out  16  latched `udp_rx_port_src`.
- `stat_data_pkts`  out  `STAT_W`  data packets forwarded.
- `stat_ctrl_pkts`  out  `STAT_W`  control packets forwarded.
- `stat_drop_port`  out  `STAT_W`  packets dropped on port mismatch.
- `stat_drop_runt`  out  `STAT_W`  packets dropped as runts.

## Operation
- Header words are big-endian. Beat 0 carries word0 = `{tdata[7:0],tdata[15:8],tdata[23:16],tdata[31:24]}` and word1 from bytes 4..7. Beat 1 carries word2 and word3 in the same way.
- Word0 bit 31 selects the packet kind: 0 = data, 1 = control.
- FSM states: IDLE, HDR1, DATA, CBODY, COUT, DROP.
- IDLE: accept beat 0; latch port, IP and words 0/1.
  - `port_dest != PORT` → DROP, increment `stat_drop_port`.
  - `tlast` set → stay IDLE, increment `stat_drop_runt`.
  - otherwise → HDR1.
- HDR1: accept beat 1; latch words 2/3.
  - `tlast` with `tkeep != 8'hFF` → IDLE, runt.
  - data packet with `tlast` (empty payload) → IDLE, runt.
  - control packet with `tlast` → COUT with body = 0.
  - control packet, otherwise → CBODY.
  - data packet, otherwise → DATA.
- DATA: forward each beat unchanged (tdata/tkeep/tlast) through a one-entry output register. On output of the `tlast` beat → IDLE, increment `stat_data_pkts`.
- CBODY: accept one beat into the body with disabled bytes zeroed.
  - `tlast` → COUT.
  - otherwise → DROP, which discards the remainder; this is not counted.
  - Because COUT is entered only after DROP ends, `udt_rx_ctrl_valid` rises after the datagram's `tlast`.
- COUT: hold `udt_rx_ctrl_valid` until ready, then → IDLE, increment `stat_ctrl_pkts`.
- DROP: accept and discard beats until `tlast`, then → IDLE.
- Shared sideband outputs (`hdr_*`, `peer_*`, `data_seq`, `ctrl_*`) stay stable from the first output valid until the corresponding final handshake.
- Counters saturate at all-ones.

## Timing
- Reset values: all valids 0, `udp_rx_tready` 0, all data/sideband outputs 0, counters 0, FSM in IDLE. Reset asserted mid-packet returns the FSM to IDLE.
  - The remainder of an interrupted input packet is then parsed as a new packet.
  - A partially sent output packet is abandoned with no `tlast`.
- `udp_rx_tready` by state:
  - 1 in IDLE, HDR1, CBODY and DROP;
  - `!data_tvalid || data_tready` in DATA;
  - 0 in COUT.
  - `tready` may depend combinationally on `udt_rx_data_tready`.
- Latency: a payload beat accepted at cycle n is presented at n+1. Full throughput of one beat per cycle when downstream is always ready.
- The output register must hold its beat under backpressure, with no loss or duplication.
- `udt_rx_ctrl_valid` asserts the cycle after the last accepted body beat, or after beat 1 for a header-only packet.
- Back-to-back packets: beat 0 of the next packet may be accepted in the cycle after the output `tlast` handshake.

## Configuration
- `UDT_RX_STATS_EN` defined: the four counters are implemented as specified.
- `UDT_RX_STATS_EN` undefined: no counter flops; all four `stat_*` outputs are tied to 0. All other behaviour is identical.

## Test plan
- Data packet, port 10086, word0 = 0x00000005, 40 bytes (5 beats): 3 payload beats out unchanged, last `tkeep` as input, `udt_rx_data_seq` = 5, `stat_data_pkts` = 1.
- Control packet, word0 = 0x80020000, 24 bytes: one descriptor with `ctrl_type` = 2, `ctrl_ext` = 0, body = beat 2; no data-output activity; `stat_ctrl_pkts` = 1.
- Packet with `port_dest` = 9999: all beats accepted, no output valid, `stat_drop_port` = 1.
- 12-byte packet (beat 1 `tkeep` = 8'h0F), then an 8-byte packet: both dropped, `stat_drop_runt` = 2.
- Data packet with random `udt_rx_data_tready` (50%) while reset is pulsed mid-packet: before reset, the output stream is lossless and in order; after reset, all outputs are 0 and the next valid packet parses correctly.
- Build without `UDT_RX_STATS_EN`: repeat test 1; `stat_*` = 0 and the data output is identical.
